// File: rtl/somador_pkg.sv
// Shared operation codes and result-register states for the adder/accumulator.
package somador_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/somador_nucleo.sv
// Combinational WIDTH-bit add/sub core with carry/borrow, signed overflow
// and optional unsigned clamping.
module somador_nucleo #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  input  logic             sat,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0] raw;

  always_comb begin
    raw      = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    carry    = raw[WIDTH];
    // Add overflows on equal operand signs, subtract on differing signs.
    overflow = ((x[WIDTH-1] ^ y[WIDTH-1]) == sub) && (raw[WIDTH-1] != x[WIDTH-1]);
    if (sat && carry) begin
      res = sub ? '0 : '1;
    end else begin
      res = raw[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/somador_acumulador.sv
// Registered add/sub/accumulate unit with a one-deep valid/ready result
// register (latency 1, full throughput) and a saturating ACC counter.
module somador_acumulador
  import somador_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] soma,
  output logic             carry,
  output logic             overflow,
  output logic [CNT_W-1:0] acc_count
);

  op_t              op_s;
  state_t           state_q;
  logic [WIDTH-1:0] soma_q, soma_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x, y, core_res;
  logic             carry_q, carry_d, ovf_q, ovf_d;
  logic             core_c, core_o;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign op_s      = op_t'(op);
  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // ACC feeds the accumulator through the same adder as a plain ADD.
  assign x = (op_s == OP_ACC) ? acc_q : a;
  assign y = (op_s == OP_ACC) ? a : b;

  somador_nucleo #(.WIDTH(WIDTH)) u_nucleo (
    .x        (x),
    .y        (y),
    .sub      (op_s == OP_SUB),
    .sat      (SATURATE != 0),
    .res      (core_res),
    .carry    (core_c),
    .overflow (core_o)
  );

  always_comb begin
    soma_d  = core_res;
    carry_d = core_c;
    ovf_d   = core_o;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (op_s)
      OP_ACC: begin
        acc_d = core_res;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
      OP_CLR: begin
        soma_d  = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        acc_d   = '0;
        cnt_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      soma_q  <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_q <= ST_FULL;
        ST_FULL:  if (!accept && out_ready) state_q <= ST_EMPTY;
        default:  state_q <= ST_EMPTY;
      endcase
      if (accept) begin
        soma_q  <= soma_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
        acc_q   <= acc_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  assign soma      = soma_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign acc_count = cnt_q;

endmodule

// File: tb/tb_somador_acumulador.sv
// Bench for somador_acumulador: three configurations driven in lockstep,
// checked every cycle against an arithmetic model plus literal expectations.
module tb_somador_acumulador;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [1:0] op = 2'b00;

  logic       rdy_w  [N];
  logic       vld_w  [N];
  logic [3:0] soma_w [N];
  logic       cy_w   [N];
  logic       ov_w   [N];
  logic [7:0] cnt_w  [N];

  int errors = 0;
  int checks = 0;

  // model state, one slot per instance
  bit mv   [N];
  int ms   [N];
  bit mc   [N];
  bit mo   [N];
  int macc [N];
  int mcnt [N];

  always #5 clk = ~clk;

  // 0: wrap, CNT_W=8   1: saturate, CNT_W=8   2: wrap, CNT_W=2
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      localparam int CW = (gi == 2) ? 2 : 8;
      logic [CW-1:0] cnt_l;
      somador_acumulador #(.WIDTH(4), .SATURATE((gi == 1) ? 1 : 0), .CNT_W(CW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (rdy_w[gi]),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (vld_w[gi]),
        .out_ready (out_ready),
        .soma      (soma_w[gi]),
        .carry     (cy_w[gi]),
        .overflow  (ov_w[gi]),
        .acc_count (cnt_l)
      );
      assign cnt_w[gi] = 8'(cnt_l);
    end
  endgenerate

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sg(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  // Result of one accepted operation from plain integer arithmetic.
  function automatic void model_op(input int i);
    int  s, ss;
    bit  sat;
    int  cmax;
    sat  = (i == 1);
    cmax = (i == 2) ? 3 : 255;
    case (op)
      2'b00: begin
        s = int'(a) + int'(b); ss = sg(int'(a)) + sg(int'(b));
        mc[i] = (s > 15); mo[i] = (ss > 7 || ss < -8);
        ms[i] = (sat && mc[i]) ? 15 : s % 16;
      end
      2'b01: begin
        s = int'(a) - int'(b); ss = sg(int'(a)) - sg(int'(b));
        mc[i] = (s < 0); mo[i] = (ss > 7 || ss < -8);
        ms[i] = (sat && mc[i]) ? 0 : (s + 16) % 16;
      end
      2'b10: begin
        s = macc[i] + int'(a); ss = sg(macc[i]) + sg(int'(a));
        mc[i] = (s > 15); mo[i] = (ss > 7 || ss < -8);
        ms[i] = (sat && mc[i]) ? 15 : s % 16;
        macc[i] = ms[i];
        if (mcnt[i] < cmax) mcnt[i]++;
      end
      default: begin
        ms[i] = 0; mc[i] = 0; mo[i] = 0; macc[i] = 0; mcnt[i] = 0;
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        mv[i] = 0; ms[i] = 0; mc[i] = 0; mo[i] = 0; macc[i] = 0; mcnt[i] = 0;
      end else if (in_valid && (!mv[i] || out_ready)) begin
        model_op(i);
        mv[i] = 1;
      end else if (out_ready) begin
        mv[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d_out_valid", i), int'(vld_w[i]), int'(mv[i]));
      chk($sformatf("u%0d_in_ready", i), int'(rdy_w[i]), int'(!mv[i] || out_ready));
      chk($sformatf("u%0d_soma", i), int'(soma_w[i]), ms[i]);
      chk($sformatf("u%0d_carry", i), int'(cy_w[i]), int'(mc[i]));
      chk($sformatf("u%0d_overflow", i), int'(ov_w[i]), int'(mo[i]));
      chk($sformatf("u%0d_acc_count", i), int'(cnt_w[i]), mcnt[i]);
    end
  end

  // Request accepted on the second edge; returns just after it.
  task automatic send(input logic [1:0] o, input logic [3:0] aa, input logic [3:0] bb);
    @(posedge clk); #2;
    in_valid = 1'b1; op = o; a = aa; b = bb;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_res(input string name, input int i, input int s, input int c, input int o);
    chk({name, "_soma"}, int'(soma_w[i]), s);
    chk({name, "_carry"}, int'(cy_w[i]), c);
    chk({name, "_ovf"}, int'(ov_w[i]), o);
    chk({name, "_valid"}, int'(vld_w[i]), 1);
  endtask

  initial begin
    #12;
    chk("reset_out_valid", int'(vld_w[0]), 0);
    chk("reset_soma", int'(soma_w[0]), 0);
    chk("reset_cnt", int'(cnt_w[0]), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    chk("reset_in_ready", int'(rdy_w[0]), 1);

    send(2'b00, 4'd10, 4'd5); expect_res("add_10_5", 0, 15, 0, 0);
    send(2'b00, 4'd15, 4'd1); expect_res("add_15_1", 0, 0, 1, 0);
    send(2'b00, 4'd8, 4'd8);  expect_res("add_8_8", 0, 0, 1, 1);
    send(2'b00, 4'd6, 4'd8);  expect_res("add_6_8", 0, 14, 0, 0);
    send(2'b01, 4'd2, 4'd3);  expect_res("sub_2_3", 0, 15, 1, 0);
    expect_res("sub_2_3_sat", 1, 0, 1, 0);
    send(2'b00, 4'd9, 4'd8);  expect_res("add_9_8_sat", 1, 15, 1, 1);
    expect_res("add_9_8", 0, 1, 1, 1);

    send(2'b11, 4'd0, 4'd0);  expect_res("clr", 0, 0, 0, 0);
    send(2'b10, 4'd7, 4'd0);  chk("acc1_soma", int'(soma_w[0]), 7);
    send(2'b10, 4'd7, 4'd0);  chk("acc2_soma", int'(soma_w[0]), 14);
    send(2'b10, 4'd3, 4'd0);
    chk("acc3_soma", int'(soma_w[0]), 1);
    chk("acc3_carry", int'(cy_w[0]), 1);
    chk("acc3_cnt", int'(cnt_w[0]), 3);
    chk("acc3_soma_sat", int'(soma_w[1]), 15);
    send(2'b10, 4'd0, 4'd0);
    chk("acc4_sat_held", int'(soma_w[1]), 15);
    chk("acc4_wrap", int'(soma_w[0]), 1);
    send(2'b10, 4'd0, 4'd0);
    chk("acc5_cnt_w2", int'(cnt_w[2]), 3);
    chk("acc5_cnt_w8", int'(cnt_w[0]), 5);
    send(2'b11, 4'd0, 4'd0);
    chk("clr_cnt_w2", int'(cnt_w[2]), 0);

    // backpressure: result held, new requests ignored, then no-bubble handoff
    @(posedge clk); #2;
    out_ready = 1'b0; in_valid = 1'b1; op = 2'b00; a = 4'd2; b = 4'd3;
    @(posedge clk); #1;
    chk("bp_soma", int'(soma_w[0]), 5);
    a = 4'd4; b = 4'd4;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_soma", int'(soma_w[0]), 5);
      chk("bp_hold_valid", int'(vld_w[0]), 1);
      chk("bp_hold_in_ready", int'(rdy_w[0]), 0);
    end
    out_ready = 1'b1; a = 4'd1; b = 4'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_res("bp_next", 0, 2, 0, 0);

    // asynchronous reset in the middle of a hold
    send(2'b11, 4'd0, 4'd0);
    send(2'b10, 4'd4, 4'd0);
    send(2'b10, 4'd5, 4'd0);
    out_ready = 1'b0;
    chk("pre_rst_soma", int'(soma_w[0]), 9);
    chk("pre_rst_cnt", int'(cnt_w[0]), 2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(vld_w[0]), 0);
    chk("rst_soma", int'(soma_w[0]), 0);
    chk("rst_carry", int'(cy_w[0]), 0);
    chk("rst_ovf", int'(ov_w[0]), 0);
    chk("rst_cnt", int'(cnt_w[0]), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    #1 chk("rst_in_ready", int'(rdy_w[0]), 1);
    out_ready = 1'b1;
    send(2'b10, 4'd1, 4'd0);
    expect_res("rst_acc_zeroed", 0, 1, 0, 0);
    chk("rst_acc_cnt", int'(cnt_w[0]), 1);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/somador_acumulador.md
Name: somador_acumulador

Overview:
- Parametrised, registered successor to the 4-bit combinational adder.
- Adds or subtracts two WIDTH-bit operands, or accumulates operand a into an internal register.
- Reports carry/borrow and signed overflow, with optional unsigned saturation.
- Sits between a producer and a consumer using valid/ready handshakes, with one result register (latency 1, throughput 1/cycle).

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).
- SATURATE, 0, 1 = clamp results to the unsigned range on carry/borrow; 0 = wrap modulo 2^WIDTH.
- CNT_W, 8, width of the accumulated-operand counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request this cycle.
- a  in  WIDTH  operand A (unsigned; also read as two's complement for overflow).
- b  in  WIDTH  operand B; ignored for ACC and CLR.
- op  in  2  operation: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer takes the result this cycle.
- soma  out  WIDTH  result.
- carry  out  1  ADD/ACC: carry out of the MSB; SUB: borrow (a<b unsigned).
- overflow  out  1  signed two's-complement overflow of the operation.
- acc_count  out  CNT_W  ACC operations accepted since the last CLR or reset (saturating).

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: out_valid=0, soma=0, carry=0, overflow=0, accumulator=0, acc_count=0.
- Reset mid-operation discards any held result. No output is produced for it.
- Result register FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
  - in_ready = !out_valid || out_ready (combinational).
- Accept: in_valid && in_ready at a rising edge. The result is registered on that edge, so out_valid=1 from the next cycle (latency 1).
- Transitions:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on out_ready with no accept.
  - FULL -> FULL on simultaneous out_ready and accept: the new result replaces the old one in the same cycle, with no bubble.
- Hold: while FULL and out_ready=0, soma/carry/overflow stay stable and no request is accepted.
- Arithmetic uses a WIDTH+1-bit raw result.
  - ADD: raw = a+b. carry = raw[WIDTH]. overflow = (a[MSB]==b[MSB]) && (raw[MSB-1]!=a[MSB]), where MSB-1 means bit WIDTH-1 of raw.
  - SUB: raw = a-b. carry = borrow. overflow = (a[MSB]!=b[MSB]) && (result MSB != a[MSB]).
  - ACC: same as ADD, with operands accumulator and a. The accumulator updates to the (possibly saturated) soma. acc_count increments, holding at 2^CNT_W-1.
  - CLR: accumulator=0 and acc_count=0. Output soma=0, carry=0, overflow=0.
- Saturation (SATURATE=1):
  - ADD/ACC with carry: soma = all ones.
  - SUB with borrow: soma = 0.
  - carry and overflow still report the unsaturated condition.
- Wrap (SATURATE=0): soma = raw[WIDTH-1:0].
- ADD/SUB do not touch the accumulator or acc_count.
- acc_count is a live register, updated on the accept edge, independent of out_ready.
- in_valid is ignored while in_ready=0. The producer holds its inputs until accepted.

Decomposition:
- Package somador_pkg: op encodings (OP_ADD, OP_SUB, OP_ACC, OP_CLR) and the op_t 2-bit typedef.
- One sub-module, somador_nucleo:
  - combinational WIDTH-parametrised add/sub core, with ports x, y, sub, sat;
  - outputs res, carry, overflow.
- The top level holds the handshake FSM, result register, accumulator and counter.

Test Plan:
- WIDTH=4, SATURATE=0, out_ready=1, ADD pairs (10,5), (15,1), (8,8), (6,8) -> soma/carry/overflow = 15/0/0, 0/1/0, 0/1/1, 14/0/0; each result one cycle after accept.
- SUB 2-3 -> soma=15, carry=1, overflow=0. Same with SATURATE=1 -> soma=0, carry=1. SATURATE=1 ADD 9+8 -> soma=15, carry=1, overflow=1.
- CLR, then ACC a=7, a=7, a=3 -> soma 7, 14, 1 (carry=1 on the last); acc_count=3. With SATURATE=1 the last result is 15 and the accumulator stays 15.
- Backpressure: ADD 2+3 accepted, out_ready=0 for 3 cycles -> soma=5 held, out_valid=1, in_ready=0, new requests ignored. out_ready=1 with in_valid=1 (ADD 1+1) -> soma=2 next cycle, no bubble.
- Reset: assert rst_n=0 asynchronously mid-hold (between clock edges) with acc=9, acc_count=2 -> out_valid, soma, carry, overflow, accumulator and acc_count all 0 immediately; in_ready=1 after release.
- acc_count saturation with CNT_W=2: 5 ACC ops -> acc_count stays at 3; CLR -> 0.
